// File: rtl/mem_arbiter_n.sv
// N-master shared-memory arbiter: master 0 has high priority and may preempt,
// masters 1..N-1 rotate round-robin, and preemptions are counted.
module mem_arbiter_n #(
   parameter int unsigned N_MASTERS    = 3,
   parameter int unsigned MAX_HOLD     = 2,
   parameter int unsigned PREEMPT_HOLD = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_MASTERS-1:0]         req,
   input  logic [N_MASTERS-1:0]         done,
   output logic [N_MASTERS-1:0]         grant,
   output logic                         grant_valid,
   output logic [$clog2(N_MASTERS)-1:0] grant_id,
   output logic                         preempt_pulse,
   output logic [CNT_W-1:0]             nb_interrupts
);

   localparam int unsigned ID_W     = $clog2(N_MASTERS);
   localparam int unsigned HOLD_MAX = (MAX_HOLD > PREEMPT_HOLD) ? MAX_HOLD : PREEMPT_HOLD;
   localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LP     = 2'd1,
      S_HP     = 2'd2,
      S_HP_PRE = 2'd3
   } state_t;

   state_t            st, st_nxt;
   logic [ID_W-1:0]   owner, owner_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [ID_W-1:0]   rr_ptr, rr_nxt;
   logic [CNT_W-1:0]  nb_cnt, cnt_nxt;

   logic              lp_found;
   logic [ID_W-1:0]   lp_idx;
   logic              run_full;
   logic              run_lp;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st       <= S_IDLE;
         owner    <= '0;
         hold_cnt <= '0;
         rr_ptr   <= ID_W'(1);
         nb_cnt   <= '0;
      end else begin
         st       <= st_nxt;
         owner    <= owner_nxt;
         hold_cnt <= hold_nxt;
         rr_ptr   <= rr_nxt;
         nb_cnt   <= cnt_nxt;
      end
   end

   // Round-robin scan of low-priority requesters starting at rr_ptr
   always_comb begin
      int unsigned k;
      k        = 0;
      lp_found = 1'b0;
      lp_idx   = '0;
      for (int unsigned i = 0; i < N_MASTERS - 1; i++) begin
         k = 32'(rr_ptr) + i;
         if (k >= N_MASTERS) k = k - (N_MASTERS - 1);
         if (!lp_found && req[k]) begin
            lp_found = 1'b1;
            lp_idx   = ID_W'(k);
         end
      end
   end

   // Next-state logic; re-arbitration outcomes are applied after the case
   always_comb begin
      st_nxt    = st;
      owner_nxt = owner;
      hold_nxt  = hold_cnt;
      rr_nxt    = rr_ptr;
      cnt_nxt   = nb_cnt;
      run_full  = 1'b0;
      run_lp    = 1'b0;
      case (st)
         S_IDLE: run_full = 1'b1;
         S_LP: begin
            if (done[owner] || hold_cnt == HOLD_W'(MAX_HOLD)) begin
               run_full = 1'b1;
            end else if (req[0]) begin
               st_nxt    = S_HP_PRE;
               owner_nxt = '0;
               hold_nxt  = HOLD_W'(1);
               rr_nxt    = owner;
               if (nb_cnt != {CNT_W{1'b1}}) cnt_nxt = nb_cnt + CNT_W'(1);
            end else begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         S_HP: begin
            if (done[0]) run_lp = 1'b1;
         end
         S_HP_PRE: begin
            if (done[0] || hold_cnt == HOLD_W'(PREEMPT_HOLD)) run_lp = 1'b1;
            else hold_nxt = hold_cnt + HOLD_W'(1);
         end
         default: begin
            st_nxt    = S_IDLE;
            owner_nxt = '0;
            hold_nxt  = '0;
         end
      endcase

      if (run_full && req[0]) begin
         st_nxt    = S_HP;
         owner_nxt = '0;
         hold_nxt  = HOLD_W'(1);
      end else if (run_full || run_lp) begin
         if (lp_found) begin
            st_nxt    = S_LP;
            owner_nxt = lp_idx;
            hold_nxt  = HOLD_W'(1);
            rr_nxt    = (lp_idx == ID_W'(N_MASTERS - 1)) ? ID_W'(1) : lp_idx + ID_W'(1);
         end else begin
            st_nxt    = S_IDLE;
            owner_nxt = '0;
            hold_nxt  = '0;
         end
      end
   end

   // Output decode of registered state only
   always_comb begin
      grant         = '0;
      grant_valid   = 1'b0;
      grant_id      = '0;
      preempt_pulse = 1'b0;
      nb_interrupts = nb_cnt;
      if (st != S_IDLE) begin
         grant[owner] = 1'b1;
         grant_valid  = 1'b1;
         grant_id     = owner;
      end
      if (st == S_HP_PRE && hold_cnt == HOLD_W'(1)) preempt_pulse = 1'b1;
   end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Scoreboard bench for mem_arbiter_n: directed vectors push expected grants,
// a monitor pops and checks after each edge (two DUTs: CNT_W=2 and CNT_W=32).
module tb_mem_arbiter_n;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req;
   logic [2:0]  done;

   logic [2:0]  g2, g32;
   logic        v2, v32;
   logic [1:0]  id2, id32;
   logic        p2, p32;
   logic [1:0]  nb2;
   logic [31:0] nb32;

   typedef struct {
      logic [2:0]  grant;
      logic        pulse;
      logic [31:0] cnt;
      string       tag;
   } exp_t;

   exp_t q[$];
   event sample_ev;
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_arbiter_n #(.N_MASTERS(3), .MAX_HOLD(2), .PREEMPT_HOLD(2), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .grant(g2), .grant_valid(v2), .grant_id(id2),
      .preempt_pulse(p2), .nb_interrupts(nb2)
   );

   mem_arbiter_n #(.N_MASTERS(3), .MAX_HOLD(2), .PREEMPT_HOLD(2), .CNT_W(32)) dut32 (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .grant(g32), .grant_valid(v32), .grant_id(id32),
      .preempt_pulse(p32), .nb_interrupts(nb32)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%s] @%0t: got %0h expected %0h", name, tag, $time, act, exp);
      end
   endtask

   function automatic logic [1:0] id_of(input logic [2:0] g);
      case (g)
         3'b010:  return 2'd1;
         3'b100:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   // Monitor: compares every pending expectation shortly after a clock edge or async event
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or sample_ev);
         #2;
         while (q.size() > 0) begin
            e = q.pop_front();
            chk("grant2",  e.tag, 32'(g2),  32'(e.grant));
            chk("grant32", e.tag, 32'(g32), 32'(e.grant));
            chk("valid",   e.tag, 32'(v2),  32'(|e.grant));
            chk("id",      e.tag, 32'(id2), 32'(id_of(e.grant)));
            chk("pulse",   e.tag, 32'(p2),  32'(e.pulse));
            chk("nb2",     e.tag, 32'(nb2), (e.cnt > 3) ? 32'd3 : e.cnt);
            chk("nb32",    e.tag, nb32,     e.cnt);
         end
      end
   end

   // Called at a negedge: drive inputs, queue the post-edge expectation, return at next negedge
   task automatic step(input logic [2:0] r, input logic [2:0] d, input logic [2:0] g,
                       input logic p, input int cnt, input string tag);
      exp_t e;
      req  = r;
      done = d;
      e.grant = g;
      e.pulse = p;
      e.cnt   = 32'(cnt);
      e.tag   = tag;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      done  = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      reset = 1'b1;
      req   = '0;
      done  = '0;
      @(negedge clk);

      // Reset state with random requests, then idle after release
      step(3'($urandom_range(0, 7)), 3'b000, 3'b000, 1'b0, 0, "rst_a");
      step(3'($urandom_range(0, 7)), 3'b000, 3'b000, 1'b0, 0, "rst_b");
      reset = 1'b0;
      step(3'b000, 3'b000, 3'b000, 1'b0, 0, "idle_a");
      step(3'b000, 3'b000, 3'b000, 1'b0, 0, "idle_b");

      // Round-robin between masters 1 and 2 with hold limit 2
      step(3'b110, 3'b000, 3'b010, 1'b0, 0, "rr1");
      step(3'b110, 3'b000, 3'b010, 1'b0, 0, "rr2");
      step(3'b110, 3'b000, 3'b100, 1'b0, 0, "rr3");
      step(3'b110, 3'b000, 3'b100, 1'b0, 0, "rr4");
      step(3'b110, 3'b000, 3'b010, 1'b0, 0, "rr5");
      do_reset();

      // Preemption of master 1, which regains first priority
      step(3'b010, 3'b000, 3'b010, 1'b0, 0, "pre_lp");
      step(3'b011, 3'b000, 3'b001, 1'b1, 1, "pre_hit");
      step(3'b110, 3'b000, 3'b001, 1'b0, 1, "pre_hold");
      step(3'b110, 3'b000, 3'b010, 1'b0, 1, "pre_back");
      do_reset();

      // Unlimited master 0 hold, no re-grant on its release cycle
      for (int i = 0; i < 10; i++) step(3'b001, 3'b000, 3'b001, 1'b0, 0, "hp_hold");
      step(3'b011, 3'b001, 3'b010, 1'b0, 0, "hp_rel");
      step(3'b000, 3'b000, 3'b010, 1'b0, 0, "hp_lp");
      do_reset();

      // Counter saturation on the 2-bit instance, linear on the 32-bit one
      step(3'b010, 3'b000, 3'b010, 1'b0, 0, "sat_start");
      for (int n = 1; n <= 5; n++) begin
         step(3'b011, 3'b000, 3'b001, 1'b1, n, "sat_pre");
         step(3'b010, 3'b000, 3'b001, 1'b0, n, "sat_hold");
         step(3'b010, 3'b000, 3'b010, 1'b0, n, "sat_back");
      end
      do_reset();

      // Async reset during a preemption grant of master 2; rr_ptr must restart at 1
      step(3'b110, 3'b000, 3'b010, 1'b0, 0, "ar1");
      step(3'b110, 3'b000, 3'b010, 1'b0, 0, "ar2");
      step(3'b110, 3'b000, 3'b100, 1'b0, 0, "ar3");
      step(3'b101, 3'b000, 3'b001, 1'b1, 1, "ar_pre");
      #1;
      reset   = 1'b1;
      e.grant = 3'b000;
      e.pulse = 1'b0;
      e.cnt   = 32'd0;
      e.tag   = "async_rst";
      q.push_back(e);
      -> sample_ev;
      #3;
      @(negedge clk);
      req   = 3'b000;
      reset = 1'b0;
      step(3'b110, 3'b000, 3'b010, 1'b0, 0, "post_rst");

      @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expectations expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
